// File: rtl/eth_frame_checker.sv
// Receive-side checker for the packet generator's test frames: a 32-bit sequence header followed by an
// incrementing byte payload. Judges every committed frame and keeps saturating good/bad/drop statistics.
module eth_frame_checker #(
    parameter int FRAME_LEN = 64,
    parameter int CNT_WIDTH = 32,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_start,
    input  logic                 rx_data_valid,
    input  logic [2:0]           rx_bytes_valid,
    input  logic [31:0]          rx_data,
    input  logic                 rx_commit,
    input  logic                 rx_drop,
    output logic                 frame_done,
    output logic                 frame_ok,
    output logic                 seq_err,
    output logic                 len_err,
    output logic                 data_err,
    output logic [31:0]          last_seq,
    output logic [CNT_WIDTH-1:0] good_count,
    output logic [CNT_WIDTH-1:0] bad_count,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
    logic [31:0]          frm_seq_q, frm_seq_d;
    logic                 frm_hdr_short_q, frm_hdr_short_d;
    logic                 frm_data_err_q, frm_data_err_d;
    logic                 seq_locked_q, seq_locked_d;
    logic                 frame_done_q, frame_done_d;
    logic                 frame_ok_q, frame_ok_d;
    logic                 seq_err_q, seq_err_d;
    logic                 len_err_q, len_err_d;
    logic                 data_err_q, data_err_d;
    logic [31:0]          last_seq_q, last_seq_d;
    logic [CNT_WIDTH-1:0] good_q, good_d;
    logic [CNT_WIDTH-1:0] bad_q, bad_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;
    logic                 busy_q, busy_d;

    logic                 in_frame;
    logic [2:0]           nbytes;
    logic [LEN_WIDTH:0]   byte_sum;
    logic [LEN_WIDTH:0]   off;
    logic [7:0]           exp_byte;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        // NOTE: every _d starts from a hold/default value so no path through this block infers a latch.
        state_d         = state_q;
        byte_cnt_d      = byte_cnt_q;
        frm_seq_d       = frm_seq_q;
        frm_hdr_short_d = frm_hdr_short_q;
        frm_data_err_d  = frm_data_err_q;
        seq_locked_d    = seq_locked_q;
        frame_done_d    = 1'b0;
        frame_ok_d      = frame_ok_q;
        seq_err_d       = seq_err_q;
        len_err_d       = len_err_q;
        data_err_d      = data_err_q;
        last_seq_d      = last_seq_q;
        good_d          = good_q;
        bad_d           = bad_q;
        drop_d          = drop_q;
        off             = '0;
        exp_byte        = '0;

        in_frame = (state_q != IDLE);
        nbytes   = (rx_bytes_valid > 3'd4) ? 3'd4 : rx_bytes_valid;
        byte_sum = {1'b0, byte_cnt_q} + (LEN_WIDTH+1)'(nbytes);

        // A word arriving with commit/drop/start still belongs to the frame in progress.
        if (in_frame && rx_data_valid) begin
            byte_cnt_d = byte_sum[LEN_WIDTH] ? '1 : byte_sum[LEN_WIDTH-1:0];
            if (state_q == HDR) begin
                frm_seq_d       = rx_data;
                frm_hdr_short_d = (nbytes < 3'd4);
                state_d         = BODY;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    off      = {1'b0, byte_cnt_q} + (LEN_WIDTH+1)'(i);
                    exp_byte = frm_seq_q[7:0] + off[7:0];
                    if (i < int'(nbytes) && off >= (LEN_WIDTH+1)'(4) && rx_data[31-8*i -: 8] != exp_byte)
                        frm_data_err_d = 1'b1;
                end
            end
        end

        if (in_frame && rx_drop) begin
            drop_d  = sat_inc(drop_q);
            state_d = IDLE;
        end else if (in_frame && rx_commit) begin
            seq_err_d = 1'b0;
            // A frame committed before its header word carries no sequence number to judge.
            if (state_d == BODY) begin
                seq_err_d    = seq_locked_q && (frm_seq_d != last_seq_q + 32'd1);
                last_seq_d   = frm_seq_d;
                seq_locked_d = 1'b1;
            end
            len_err_d    = frm_hdr_short_d || (byte_cnt_d != LEN_WIDTH'(FRAME_LEN));
            data_err_d   = frm_data_err_d;
            frame_ok_d   = !(seq_err_d || len_err_d || data_err_d);
            frame_done_d = 1'b1;
            if (frame_ok_d) good_d = sat_inc(good_q);
            else            bad_d  = sat_inc(bad_q);
            state_d = IDLE;
        end else if (in_frame && rx_start) begin
            bad_d = sat_inc(bad_q);
        end

        if (rx_start) begin
            state_d         = HDR;
            byte_cnt_d      = '0;
            frm_seq_d       = '0;
            frm_hdr_short_d = 1'b0;
            frm_data_err_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            byte_cnt_q      <= '0;
            frm_seq_q       <= '0;
            frm_hdr_short_q <= 1'b0;
            frm_data_err_q  <= 1'b0;
            seq_locked_q    <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_ok_q      <= 1'b0;
            seq_err_q       <= 1'b0;
            len_err_q       <= 1'b0;
            data_err_q      <= 1'b0;
            last_seq_q      <= '0;
            good_q          <= '0;
            bad_q           <= '0;
            drop_q          <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            byte_cnt_q      <= byte_cnt_d;
            frm_seq_q       <= frm_seq_d;
            frm_hdr_short_q <= frm_hdr_short_d;
            frm_data_err_q  <= frm_data_err_d;
            seq_locked_q    <= seq_locked_d;
            frame_done_q    <= frame_done_d;
            frame_ok_q      <= frame_ok_d;
            seq_err_q       <= seq_err_d;
            len_err_q       <= len_err_d;
            data_err_q      <= data_err_d;
            last_seq_q      <= last_seq_d;
            good_q          <= good_d;
            bad_q           <= bad_d;
            drop_q          <= drop_d;
            busy_q          <= busy_d;
        end
    end

    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign seq_err    = seq_err_q;
    assign len_err    = len_err_q;
    assign data_err   = data_err_q;
    assign last_seq   = last_seq_q;
    assign good_count = good_q;
    assign bad_count  = bad_q;
    assign drop_count = drop_q;
    assign busy       = busy_q;

endmodule
